// File: rtl/counter_cmd_arbiter.sv
// Round-robin front end that serialises read/inc/dec/load commands from NREQ
// requesters onto one shared saturating counter and returns the updated count.
module counter_cmd_arbiter #(
    parameter int  N    = 8,
    parameter int  NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [N*NREQ-1:0] req_din,
    output logic [NREQ-1:0]   req_ready,
    output logic              cnt_load,
    output logic              cnt_inc,
    output logic              cnt_dec,
    output logic [N-1:0]      cnt_din,
    input  logic [N-1:0]      cnt_count,
    input  logic              cnt_saturated,
    input  logic              cnt_zeroed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [N-1:0]      rsp_count,
    output logic              rsp_sat,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_inc_q, cnt_inc_d;
    logic          cnt_dec_q, cnt_dec_d;
    logic [N-1:0]  cnt_din_q, cnt_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]  rsp_count_q, rsp_count_d;
    logic          rsp_sat_q, rsp_sat_d;
    logic          rsp_zero_q, rsp_zero_d;

    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] scan_idx;
    logic [1:0]    sel_op;
    logic [N-1:0]  sel_din;

    // Circular priority scan starting at rr_ptr, then mux out the winner's command.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        sel_op    = '0;
        sel_din   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IW'(k)) begin
                sel_op  = req_op[2*k +: 2];
                sel_din = req_din[N*k +: N];
            end
        end
    end

    // NOTE: every flop is cleared by the asynchronous reset and updated with
    // non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_load_q  <= 1'b0;
            cnt_inc_q   <= 1'b0;
            cnt_dec_q   <= 1'b0;
            cnt_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            rsp_sat_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_load_q  <= cnt_load_d;
            cnt_inc_q   <= cnt_inc_d;
            cnt_dec_q   <= cnt_dec_d;
            cnt_din_q   <= cnt_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            rsp_sat_q   <= rsp_sat_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: each signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        req_ready   = '0;
        rr_ptr_d    = rr_ptr_q;
        cnt_load_d  = 1'b0;
        cnt_inc_d   = 1'b0;
        cnt_dec_d   = 1'b0;
        cnt_din_d   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        rsp_sat_d   = rsp_sat_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            IDLE: begin
                // Grant is combinational, so it is masked while reset is held.
                if (grant_vld && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    cnt_load_d = (sel_op == OP_LOAD);
                    cnt_inc_d  = (sel_op == OP_INC);
                    cnt_dec_d  = (sel_op == OP_DEC);
                    cnt_din_d  = sel_din;
                    rsp_id_d   = grant_idx;
                    rr_ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            CAPTURE: begin
                rsp_count_d = cnt_count;
                rsp_sat_d   = cnt_saturated;
                rsp_zero_d  = cnt_zeroed;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_inc   = cnt_inc_q;
    assign cnt_dec   = cnt_dec_q;
    assign cnt_din   = cnt_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;
    assign rsp_sat   = rsp_sat_q;
    assign rsp_zero  = rsp_zero_q;

endmodule
